// File: rtl/lcd_touch_pkg.sv
// Shared definitions for the LCD touch-interrupt sequencer: state codes,
// Avalon register addresses and register bit positions.
package lcd_touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_REQ     = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_HOLDOFF = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_PENDING   = 1;
  localparam int STAT_DONE      = 2;
  localparam int STAT_TIMEOUT   = 3;
  localparam int STAT_STATE_LSB = 4;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/lcd_touch_sync_edge.sv
// Two-flop synchroniser for an active-low panel pin with a one-cycle
// falling-edge pulse; flops reset high so reset release never looks like an edge.
module lcd_touch_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin_n,
  output logic fall
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pin_n;
      sync2 <= sync1;
    end
  end

  assign fall = sync2 & ~sync1;

endmodule

// File: rtl/lcd_touch_int_sequencer.sv
// Touch-interrupt sequencer: edge detect, hold-off, fetch handshake with
// timeout, event counter and CPU interrupt behind a small Avalon-MM slave.
module lcd_touch_int_sequencer
  import lcd_touch_pkg::*;
#(
  parameter int HOLDOFF_W   = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        touch_int_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        fetch_done
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t                 state, next_state;
  logic                   enable, irq_en;
  logic [HOLDOFF_W-1:0]   holdoff_reg, hold_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [CNT_W-1:0]       count;
  logic                   pending, done, timeout;
  logic                   touch_fall, wr;
  logic                   load_hold, ack_taken, done_evt, timeout_evt;
  logic [31:0]            read_mux;
  logic                   unused_bits;

  assign unused_bits = ^writedata[31:HOLDOFF_W];

  lcd_touch_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .pin_n (touch_int_n),
    .fall  (touch_fall)
  );

  assign wr        = chipselect & ~write_n;
  assign fetch_req = (state == ST_REQ);
  assign irq       = irq_en & (done | timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Dropping enable forces IDLE and suppresses any event of the current cycle.
  always_comb begin
    next_state  = state;
    load_hold   = 1'b0;
    ack_taken   = 1'b0;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && (touch_fall || pending)) begin
          load_hold  = 1'b1;
          next_state = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt == '0) next_state = ST_REQ;
      end
      ST_REQ: begin
        if (fetch_ack) begin
          ack_taken  = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fetch_done) begin
          done_evt   = 1'b1;
          next_state = ST_IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          timeout_evt = 1'b1;
          next_state  = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (!enable) begin
      next_state  = ST_IDLE;
      load_hold   = 1'b0;
      ack_taken   = 1'b0;
      done_evt    = 1'b0;
      timeout_evt = 1'b0;
    end
  end

  // Hardware sets beat CPU clears; a COUNT write beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      holdoff_reg <= '0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      count       <= '0;
      pending     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (load_hold)                              hold_cnt <= holdoff_reg;
      else if (state == ST_HOLDOFF && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

      if (ack_taken)              tmo_cnt <= '0;
      else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + TW'(1);

      if (!enable)                            pending <= 1'b0;
      else if (touch_fall && state != ST_IDLE) pending <= 1'b1;
      else if (load_hold)                     pending <= 1'b0;

      if (done_evt) done <= 1'b1;
      else if (wr && address == ADDR_STATUS && writedata[STAT_DONE]) done <= 1'b0;

      if (timeout_evt) timeout <= 1'b1;
      else if (wr && address == ADDR_STATUS && writedata[STAT_TIMEOUT]) timeout <= 1'b0;

      if (wr && address == ADDR_COUNT) count <= '0;
      else if (done_evt)               count <= count + CNT_W'(1);

      if (wr && address == ADDR_CTRL) begin
        enable <= writedata[CTRL_ENABLE];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (wr && address == ADDR_HOLDOFF) holdoff_reg <= writedata[HOLDOFF_W-1:0];
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_STATUS: begin
        read_mux[STAT_BUSY]                 = (state != ST_IDLE);
        read_mux[STAT_PENDING]              = pending;
        read_mux[STAT_DONE]                 = done;
        read_mux[STAT_TIMEOUT]              = timeout;
        read_mux[STAT_STATE_LSB +: 3]       = {1'b0, state};
      end
      ADDR_CTRL: begin
        read_mux[CTRL_ENABLE] = enable;
        read_mux[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_HOLDOFF: read_mux[HOLDOFF_W-1:0] = holdoff_reg;
      ADDR_COUNT:   read_mux[CNT_W-1:0]     = count;
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= read_mux;
  end

endmodule

// File: tb/tb_lcd_touch_int_sequencer.sv
// Self-checking bench for lcd_touch_int_sequencer; register reads are checked
// through an expected-value queue popped when readdata becomes valid.
module tb_lcd_touch_int_sequencer;
  import lcd_touch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        touch_int_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        fetch_req;
  logic        fetch_ack;
  logic        fetch_done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];
  logic        reqSeen = 1'b0;

  lcd_touch_int_sequencer #(
    .HOLDOFF_W   (16),
    .TIMEOUT_CYC (100),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .touch_int_n (touch_int_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .fetch_req   (fetch_req),
    .fetch_ack   (fetch_ack),
    .fetch_done  (fetch_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample just after the rising edge, return at the falling edge to drive.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (fetch_req) reqSeen = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readExpect(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    address = addr;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    cycle();
    checkOutput(tagQ.pop_front(), readdata, expQ.pop_front());
  endtask

  task automatic pinPulse();
    touch_int_n = 1'b0;
    repeat (3) cycle();
    touch_int_n = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic waitReq(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!fetch_req && n < 50);
    if (!fetch_req) checkOutput("req_wait_expired", 32'(fetch_req), 32'd1);
  endtask

  task automatic ackReq();
    fetch_ack = 1'b1;
    cycle();
    fetch_ack = 1'b0;
  endtask

  task automatic pulseDone();
    fetch_done = 1'b1;
    cycle();
    fetch_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; touch_int_n = 1'b1; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0; fetch_ack = 1'b0; fetch_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_req", 32'(fetch_req), 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);
    readExpect(ADDR_STATUS,  32'd0, "rst_status");
    readExpect(ADDR_CTRL,    32'd0, "rst_ctrl");
    readExpect(ADDR_HOLDOFF, 32'd0, "rst_holdoff");
    readExpect(ADDR_COUNT,   32'd0, "rst_count");

    // Basic sequence with hold-off 5.
    applyStimulus(ADDR_CTRL, 32'h3);
    applyStimulus(ADDR_HOLDOFF, 32'd5);
    readExpect(ADDR_CTRL, 32'h3, "ctrl_rb");
    readExpect(ADDR_HOLDOFF, 32'd5, "holdoff_rb");
    touch_int_n = 1'b0;
    waitReq(n);
    checkOutput("req_latency_h5", 32'(n >= 8 && n <= 9), 32'd1);
    repeat (2) cycle();
    checkOutput("req_held", 32'(fetch_req), 32'd1);
    ackReq();
    checkOutput("req_drop", 32'(fetch_req), 32'd0);
    repeat (10) cycle();
    pulseDone();
    checkOutput("irq_done", 32'(irq), 32'd1);
    readExpect(ADDR_STATUS, 32'h4, "status_done");
    readExpect(ADDR_COUNT, 32'd1, "count_1");
    applyStimulus(ADDR_STATUS, 32'h4);
    checkOutput("irq_cleared", 32'(irq), 32'd0);
    touch_int_n = 1'b1;
    repeat (3) cycle();

    // Pending: two edges during WAIT, only one replay.
    applyStimulus(ADDR_COUNT, 32'd0);
    touch_int_n = 1'b0;
    waitReq(n);
    touch_int_n = 1'b1;
    repeat (2) cycle();
    ackReq();
    pinPulse();
    pinPulse();
    readExpect(ADDR_STATUS, 32'h33, "status_pending");
    pulseDone();
    waitReq(n);
    checkOutput("replay_req", 32'(fetch_req), 32'd1);
    repeat (2) cycle();
    ackReq();
    repeat (3) cycle();
    pulseDone();
    reqSeen = 1'b0;
    repeat (20) cycle();
    checkOutput("third_edge_dropped", 32'(reqSeen), 32'd0);
    readExpect(ADDR_COUNT, 32'd2, "count_2");
    readExpect(ADDR_STATUS, 32'h4, "status_after_replay");

    // Timeout with no fetch_done.
    applyStimulus(ADDR_STATUS, 32'h4);
    touch_int_n = 1'b0;
    waitReq(n);
    touch_int_n = 1'b1;
    ackReq();
    n = 0;
    do begin
      cycle();
      n++;
    end while (!irq && n < 200);
    checkOutput("timeout_latency", 32'(n), 32'd100);
    readExpect(ADDR_STATUS, 32'h8, "status_timeout");
    readExpect(ADDR_COUNT, 32'd2, "count_kept");
    applyStimulus(ADDR_STATUS, 32'h8);
    checkOutput("irq_tmo_cleared", 32'(irq), 32'd0);

    // Disable during hold-off.
    applyStimulus(ADDR_HOLDOFF, 32'd20);
    reqSeen = 1'b0;
    pinPulse();
    readExpect(ADDR_STATUS, 32'h11, "status_holdoff");
    pinPulse();
    readExpect(ADDR_STATUS, 32'h13, "status_holdoff_pend");
    applyStimulus(ADDR_CTRL, 32'h2);
    cycle();
    readExpect(ADDR_STATUS, 32'h0, "disable_idle");
    pinPulse();
    pinPulse();
    repeat (10) cycle();
    readExpect(ADDR_STATUS, 32'h0, "disabled_ignores_edges");
    checkOutput("disabled_no_req", 32'(reqSeen), 32'd0);

    // Simultaneous COUNT clear / fetch_done, then done clear / fetch_done.
    applyStimulus(ADDR_CTRL, 32'h3);
    applyStimulus(ADDR_HOLDOFF, 32'd0);
    touch_int_n = 1'b0;
    waitReq(n);
    checkOutput("req_latency_h0", 32'(n >= 3 && n <= 4), 32'd1);
    touch_int_n = 1'b1;
    ackReq();
    repeat (3) cycle();
    fetch_done = 1'b1;
    address = ADDR_COUNT; writedata = '0; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    fetch_done = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    readExpect(ADDR_COUNT, 32'd0, "count_clear_wins");
    readExpect(ADDR_STATUS, 32'h4, "status_done_again");
    repeat (2) cycle();
    touch_int_n = 1'b0;
    waitReq(n);
    touch_int_n = 1'b1;
    ackReq();
    repeat (2) cycle();
    fetch_done = 1'b1;
    address = ADDR_STATUS; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    fetch_done = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    readExpect(ADDR_STATUS, 32'h4, "done_set_wins");
    readExpect(ADDR_COUNT, 32'd1, "count_after_clear");
    checkOutput("irq_final", 32'(irq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
